// File: rtl/ahb3lite_slave_port_arbiter.sv
// Slave-side AHB-Lite arbiter: picks one master by static priority, breaks ties
// round-robin, and holds the grant across bursts, locked sequences and wait states.
module ahb3lite_slave_port_arbiter #(
  parameter int MASTERS = 3,
  parameter int PRIO_W  = $clog2(MASTERS),
  localparam int IDX_W  = $clog2(MASTERS)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [MASTERS-1:0]        req,
  input  logic [MASTERS*PRIO_W-1:0] mst_priority,
  input  logic [1:0]                HTRANS,
  input  logic                      HMASTLOCK,
  input  logic                      HREADY,
  output logic [MASTERS-1:0]        gnt,
  output logic [IDX_W-1:0]          gnt_idx,
  output logic                      gnt_valid
);

  localparam logic NO_GNT  = 1'b0;
  localparam logic GRANTED = 1'b1;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic               state;
  logic [PRIO_W-1:0]  max_prio;
  logic [MASTERS-1:0] cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               arb_point;

  // SEQ/BUSY or a held lock keep the current owner; NO_GNT always re-arbitrates.
  assign arb_point = HREADY &&
                     (state == NO_GNT ||
                      (!HMASTLOCK && (HTRANS == HT_IDLE || HTRANS == HT_NONSEQ)));

  always_comb begin
    max_prio = '0;
    for (int m = 0; m < MASTERS; m++)
      if (req[m] && mst_priority[m*PRIO_W +: PRIO_W] > max_prio)
        max_prio = mst_priority[m*PRIO_W +: PRIO_W];
  end

  generate
    for (genvar m = 0; m < MASTERS; m++) begin : g_cand
      assign cand[m] = req[m] && (mst_priority[m*PRIO_W +: PRIO_W] == max_prio);
    end
  endgenerate

  // Search starts just past the last owner, so the owner itself is visited last.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = gnt_idx;
    for (int k = 1; k <= MASTERS; k++) begin
      j = int'(gnt_idx) + k;
      if (j >= MASTERS) j = j - MASTERS;
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= NO_GNT;
      gnt     <= '0;
      gnt_idx <= IDX_W'(MASTERS - 1);
    end else if (arb_point) begin
      if (win_found) begin
        state   <= GRANTED;
        gnt     <= {{(MASTERS-1){1'b0}}, 1'b1} << win_idx;
        gnt_idx <= win_idx;
      end else begin
        state <= NO_GNT;
        gnt   <= '0;
      end
    end
  end

  assign gnt_valid = (state == GRANTED);

endmodule

// File: tb/tb_ahb3lite_slave_port_arbiter.sv
// Directed bench for ahb3lite_slave_port_arbiter with MASTERS=3: a per-cycle vector
// table plus a hand-written asynchronous reset sequence.
module tb_ahb3lite_slave_port_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  // priority packing {m2, m1, m0}, 2 bits each
  localparam logic [5:0] P_ALL0 = 6'b00_00_00;
  localparam logic [5:0] P_M1HI = 6'b01_10_00;
  localparam logic [5:0] P_M2HI = 6'b10_00_00;
  localparam logic [5:0] P_M0_3 = 6'b01_01_11;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [2:0] req;
  logic [5:0] mst_priority;
  logic [1:0] HTRANS;
  logic       HMASTLOCK;
  logic       HREADY;
  logic [2:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  ahb3lite_slave_port_arbiter #(.MASTERS(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .mst_priority(mst_priority),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [2:0] req;
    logic [5:0] prio;
    logic [1:0] htrans;
    logic       lock;
    logic       hready;
    logic [2:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [2:0] r, input logic [5:0] p, input logic [1:0] t,
                     input logic l, input logic h, input logic [2:0] g,
                     input logic [1:0] i, input logic v);
    vec_t e;
    e.req = r; e.prio = p; e.htrans = t; e.lock = l; e.hready = h;
    e.gnt = g; e.idx = i; e.vld = v;
    vecs.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [2:0] eg, input logic [1:0] ei,
                     input logic ev);
    checks++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || $countones(gnt) > 1) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
               nm, gnt, gnt_idx, gnt_valid, eg, ei, ev);
    end
  endtask

  initial begin
    //   req     prio    htrans lk rdy  gnt     idx  vld
    add(3'b001, P_ALL0, NSEQ, 0, 1, 3'b001, 2'd0, 1); // first grant after reset
    add(3'b111, P_ALL0, NSEQ, 0, 1, 3'b010, 2'd1, 1); // round robin
    add(3'b111, P_ALL0, NSEQ, 0, 1, 3'b100, 2'd2, 1);
    add(3'b111, P_ALL0, NSEQ, 0, 1, 3'b001, 2'd0, 1); // wrap
    add(3'b111, P_ALL0, NSEQ, 0, 1, 3'b010, 2'd1, 1);
    add(3'b111, P_M1HI, NSEQ, 0, 1, 3'b010, 2'd1, 1); // m1 highest
    add(3'b111, P_M1HI, NSEQ, 0, 1, 3'b010, 2'd1, 1);
    add(3'b101, P_M1HI, NSEQ, 0, 1, 3'b100, 2'd2, 1); // m1 drops -> m2
    add(3'b000, P_M1HI, NSEQ, 0, 1, 3'b000, 2'd2, 0); // no req: idx kept
    add(3'b001, P_ALL0, NSEQ, 0, 1, 3'b001, 2'd0, 1); // owner 0
    add(3'b111, P_M2HI, SEQ,  0, 1, 3'b001, 2'd0, 1); // burst holds
    add(3'b111, P_M2HI, SEQ,  0, 1, 3'b001, 2'd0, 1);
    add(3'b111, P_M2HI, SEQ,  0, 1, 3'b001, 2'd0, 1);
    add(3'b110, P_M2HI, SEQ,  0, 1, 3'b001, 2'd0, 1); // owner drops req mid-burst
    add(3'b111, P_M2HI, IDLE, 0, 1, 3'b100, 2'd2, 1); // burst end -> m2
    add(3'b011, P_M2HI, BUSY, 0, 1, 3'b100, 2'd2, 1); // BUSY holds
    add(3'b001, P_M2HI, NSEQ, 0, 0, 3'b100, 2'd2, 1); // wait states hold
    add(3'b010, P_M2HI, NSEQ, 0, 0, 3'b100, 2'd2, 1);
    add(3'b000, P_M2HI, NSEQ, 0, 0, 3'b100, 2'd2, 1);
    add(3'b010, P_M2HI, NSEQ, 0, 1, 3'b010, 2'd1, 1);
    add(3'b101, P_ALL0, IDLE, 1, 1, 3'b010, 2'd1, 1); // locked owner 1
    add(3'b101, P_ALL0, IDLE, 1, 1, 3'b010, 2'd1, 1);
    add(3'b101, P_ALL0, IDLE, 0, 1, 3'b100, 2'd2, 1); // lock released
    add(3'b001, P_ALL0, NSEQ, 1, 1, 3'b100, 2'd2, 1); // lock beats NONSEQ
    add(3'b001, P_ALL0, SEQ,  0, 1, 3'b100, 2'd2, 1); // unlock during SEQ: hold
    add(3'b001, P_ALL0, IDLE, 0, 0, 3'b100, 2'd2, 1); // unlock+IDLE but not ready
    add(3'b001, P_ALL0, IDLE, 0, 1, 3'b001, 2'd0, 1);
    add(3'b000, P_ALL0, IDLE, 0, 1, 3'b000, 2'd0, 0); // to NO_GNT
    add(3'b010, P_ALL0, IDLE, 0, 0, 3'b000, 2'd0, 0); // NO_GNT waits on HREADY
    add(3'b010, P_ALL0, SEQ,  1, 1, 3'b010, 2'd1, 1); // NO_GNT ignores lock/SEQ
    add(3'b111, P_M0_3, NSEQ, 0, 1, 3'b001, 2'd0, 1); // unsigned prio 3 wins
    add(3'b111, P_M0_3, NSEQ, 0, 1, 3'b001, 2'd0, 1); // sole candidate re-wins

    HRESETn = 1'b0; req = '0; mst_priority = P_ALL0;
    HTRANS = IDLE; HMASTLOCK = 1'b0; HREADY = 1'b1;
    #12;
    chk("reset_state", 3'b000, 2'd2, 1'b0);

    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge HCLK);
      req = vecs[i].req; mst_priority = vecs[i].prio; HTRANS = vecs[i].htrans;
      HMASTLOCK = vecs[i].lock; HREADY = vecs[i].hready;
      @(posedge HCLK);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld);
    end

    // locked burst, then reset asserted between edges
    @(negedge HCLK);
    req = 3'b111; mst_priority = P_ALL0; HTRANS = SEQ; HMASTLOCK = 1'b1;
    @(posedge HCLK);
    #1;
    chk("locked_hold", 3'b001, 2'd0, 1'b1);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("async_reset_mid_lock", 3'b000, 2'd2, 1'b0);
    @(posedge HCLK);
    #1;
    chk("reset_held_over_edge", 3'b000, 2'd2, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1; HTRANS = NSEQ; HMASTLOCK = 1'b0;
    #1;
    chk("release_before_edge", 3'b000, 2'd2, 1'b0);
    @(posedge HCLK);
    #1;
    chk("first_edge_after_reset", 3'b001, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_slave_port_arbiter.md
AHB3LITE_SLAVE_PORT_ARBITER -- requirements
Module: ahb3lite_slave_port_arbiter

Interface
REQ-001 The block SHALL have parameter MASTERS, default 3, giving the number of competing master ports (>=2).
REQ-002 The block SHALL have parameter PRIO_W, default $clog2(MASTERS), giving the width of each priority field.
REQ-003 The block SHALL have port HCLK, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port HRESETn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, MASTERS bits: req[m]=1 when master m selects this slave with HTRANS!=IDLE.
REQ-006 The block SHALL have port mst_priority, input, MASTERS x PRIO_W bits: static priority per master; higher value wins.
REQ-007 The block SHALL have port HTRANS, input, 2 bits: the HTRANS of the currently granted master.
REQ-008 The block SHALL have port HMASTLOCK, input, 1 bit: the HMASTLOCK of the currently granted master.
REQ-009 The block SHALL have port HREADY, input, 1 bit: the HREADYOUT of the slave.
REQ-010 The block SHALL have port gnt, output, MASTERS bits: one-hot grant.
REQ-011 The block SHALL have port gnt_idx, output, $clog2(MASTERS) bits: the binary index of the last or current owner.
REQ-012 The block SHALL have port gnt_valid, output, 1 bit: 1 when gnt is non-zero.

Function
REQ-013 All outputs SHALL be registered, and grant SHALL change only on a rising HCLK edge.
REQ-014 The FSM SHALL have two states, NO_GNT and GRANTED; gnt_valid=1 exactly in GRANTED.
REQ-015 An arbitration point SHALL occur on an edge where HREADY=1 and one of the following holds:
- state=NO_GNT, or
- HMASTLOCK=0 and HTRANS is IDLE(00) or NONSEQ(10).
REQ-016 No arbitration point SHALL occur while HREADY=0; gnt, gnt_idx and the state SHALL hold.
REQ-017 While in GRANTED with HTRANS=SEQ(11) or BUSY(01), the grant SHALL hold regardless of req, including when the owner drops req.
REQ-018 While in GRANTED with HMASTLOCK=1, the grant SHALL hold regardless of HTRANS and req.
REQ-019 At an arbitration point, the winner SHALL be selected in two steps:
- Candidates are the masters with req=1 whose mst_priority equals the maximum priority among all requesters.
- The winner is the first candidate at index gnt_idx+1, gnt_idx+2, ..., searching upward with wrap-around from MASTERS-1 to 0.
REQ-020 The current owner SHALL be eligible, but it is searched last among equal-priority candidates, giving round-robin fairness.
REQ-021 An arbitration point with req=0 SHALL force NO_GNT and gnt=0, with gnt_idx held so that the round-robin pointer is preserved.
REQ-022 An arbitration point with any req=1 SHALL enter or stay in GRANTED, set gnt to the winner's one-hot value and set gnt_idx to the winner's index.
REQ-023 Grant latency SHALL be one cycle: a request at an arbitration edge is granted at that same edge, and gnt is visible after it.
REQ-024 Priority comparison SHALL be unsigned over PRIO_W bits, and ties SHALL be resolved only by the round-robin rule.
REQ-025 gnt SHALL never have more than one bit set.
REQ-026 Simultaneous lock release and burst end SHALL be treated as an arbitration point only when both the REQ-015 conditions and HREADY=1 hold.

Reset
REQ-027 HRESETn=0 SHALL asynchronously force state=NO_GNT, gnt=0, gnt_valid=0 and gnt_idx=MASTERS-1, so that master 0 has first round-robin precedence.
REQ-028 Assertion of HRESETn mid-burst or mid-lock SHALL abandon ownership immediately.
REQ-029 Deassertion of HRESETn SHALL take effect synchronously with HCLK.

Verification (MASTERS=3)
REQ-030 Reset, then req=001 with HREADY=1: during reset gnt=000, gnt_valid=0 and gnt_idx=2; after the first edge gnt=001 and gnt_idx=0.
REQ-031 Priorities {0,0,0}, req=111, HTRANS=NONSEQ and HREADY=1 every cycle: the grant sequence SHALL be 001, 010, 100, 001.
REQ-032 Priorities {m0=0, m1=2, m2=1}, req=111: gnt=010 repeatedly; after req1 drops, gnt=100.
REQ-033 Owner 0 with HTRANS=SEQ for 4 cycles and req=111, master 2 at higher priority: gnt stays 001; on the first edge with HTRANS=IDLE and HREADY=1, gnt becomes 100.
REQ-034 HREADY=0 for 3 cycles while the requests change: gnt, gnt_idx and gnt_valid SHALL be unchanged.
REQ-035 Owner 1 with HMASTLOCK=1 and HTRANS=IDLE, req=101: gnt stays 010; on the edge after HMASTLOCK drops, gnt becomes 100. Then assert HRESETn=0 mid-cycle: gnt=000 immediately.
